// File: rtl/pd_sched_pkg.sv
// Shared types and constants for the power-domain scheduler.
// Holds the FSM encoding, the guard length and the shared counter width helper.
package pd_sched_pkg;

  typedef enum logic [2:0] {
    PD_IDLE,
    PD_ACK,
    PD_GUARD,
    PD_WAIT_DONE,
    PD_DWELL,
    PD_FAULT
  } pd_sched_state_e;

  localparam int PD_GUARD_CYCLES = 2;

  // One down-counter covers guard, timeout and dwell, so size it for the longest.
  function automatic int pd_cnt_width(input int dwell, input int timeout);
    int longest;
    longest = (dwell > timeout) ? dwell : timeout;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/pd_rr_arb.sv
// Combinational round-robin pick: searches upward from ptr with wrap.
// Zero latency; grant is one-hot, idx is its position, any flags a valid pick.
module pd_rr_arb #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  // Scan from the farthest offset down so the nearest requester overwrites last.
  always_comb begin
    logic [IW-1:0] sel;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    sel = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sel = IW'((int'(ptr) + k) % NREQ);
      if (req[sel]) begin
        gnt = NREQ'(1) << sel;
        idx = sel;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pd_power_scheduler.sv
// Sequences one power domain's APC level from several arbitrated requesters.
// Grant-to-ready is 1 cycle for same-state requests; transitions wait on apc_done with guard, timeout and dwell.
module pd_power_scheduler
  import pd_sched_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int DWELL_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ-1:0] req_on,
  output logic [NREQ-1:0] req_ready,
  output logic [NREQ-1:0] req_err,
  output logic            apc_power,
  input  logic            apc_done,
  output logic            pd_on,
  output logic            busy,
  output logic            fault,
  input  logic            fault_clr
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = pd_cnt_width(DWELL_CYCLES, TIMEOUT_CYCLES);

  pd_sched_state_e state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   ptr;
  logic [NREQ-1:0] owner;
  logic            trans;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic            win_on;

  pd_rr_arb #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign win_on = |(req_on & arb_gnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= PD_IDLE;
      cnt       <= '0;
      ptr       <= '0;
      owner     <= '0;
      trans     <= 1'b0;
      req_ready <= '0;
      req_err   <= '0;
      apc_power <= 1'b0;
      pd_on     <= 1'b0;
      busy      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      req_ready <= '0;
      req_err   <= '0;
      case (state)
        PD_IDLE: begin
          if (arb_any) begin
            owner <= arb_gnt;
            ptr   <= (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
            busy  <= 1'b1;
            if (win_on == pd_on) begin
              trans     <= 1'b0;
              req_ready <= arb_gnt;
              state     <= PD_ACK;
            end else begin
              trans     <= 1'b1;
              apc_power <= win_on;
              cnt       <= CW'(PD_GUARD_CYCLES);
              state     <= PD_GUARD;
            end
          end
        end
        // The wrapper's done falls only after it sees the new level; mask the stale value.
        PD_GUARD: begin
          if (cnt == CW'(1)) begin
            cnt   <= CW'(TIMEOUT_CYCLES);
            state <= PD_WAIT_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PD_WAIT_DONE: begin
          if (apc_done) begin
            pd_on     <= apc_power;
            req_ready <= owner;
            state     <= PD_ACK;
          end else if (cnt == CW'(1)) begin
            req_err <= owner;
            fault   <= 1'b1;
            state   <= PD_FAULT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PD_ACK: begin
          if (trans && (DWELL_CYCLES > 0)) begin
            cnt   <= CW'(DWELL_CYCLES);
            state <= PD_DWELL;
          end else begin
            busy  <= 1'b0;
            state <= PD_IDLE;
          end
        end
        PD_DWELL: begin
          if (cnt == CW'(1)) begin
            busy  <= 1'b0;
            state <= PD_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        // Level stays where it was left; software decides when to trust it again.
        PD_FAULT: begin
          if (fault_clr) begin
            pd_on <= apc_power;
            fault <= 1'b0;
            busy  <= 1'b0;
            state <= PD_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= PD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pd_power_scheduler.md
# pd_power_scheduler

Arbitrates power-state requests from several requesters (SW register, wakeup timer, event unit, debug) for one switchable power domain. It sequences the single `power` input of that domain's APC wrapper: it drives the level, waits for the wrapper's `done`, enforces a minimum dwell time between transitions and acknowledges the requester. It sits between the SoC control logic and the APC wrapper, so the wrapper only ever sees one level change at a time.

## Interface
- `NREQ`, 4: number of requesters (2..8)
- `DWELL_CYCLES`, 16: minimum idle cycles after a completed transition (0 allowed)
- `TIMEOUT_CYCLES`, 1024: maximum cycles waiting for `apc_done` (≥4)
- `clk`  in  1  single clock
- `rst`  in  1  asynchronous, active-low reset
- `req_valid`  in  NREQ  request pending per requester
- `req_on`  in  NREQ  requested state per requester (1 = domain on)
- `req_ready`  out  NREQ  one-hot acknowledge; transfer when `req_valid & req_ready`
- `req_err`  out  NREQ  one-cycle pulse to the owner on timeout
- `apc_power`  out  1  level to the APC wrapper `power` input
- `apc_done`  in  1  APC wrapper `done`
- `pd_on`  out  1  committed domain state
- `busy`  out  1  high in any state except IDLE
- `fault`  out  1  sticky timeout flag
- `fault_clr`  in  1  clears FAULT

## Operation
- Reset values: all outputs 0, arbitration pointer 0, state IDLE.
- States: IDLE, ACK, GUARD, WAIT_DONE, DWELL, FAULT.
- IDLE: if any `req_valid`, pick winner `w` round-robin, searching from the pointer upward with wrap. Latch `w` and `req_on[w]`. The pointer becomes `w+1` mod NREQ.
  - If `req_on[w] == pd_on`, go to ACK. No APC activity.
  - Otherwise set `apc_power <= req_on[w]`, load the guard counter with 2 and go to GUARD.
- GUARD: ignore `apc_done` for 2 cycles, because the wrapper's `done` drops combinationally on the level change. Then go to WAIT_DONE and load the timeout counter.
- WAIT_DONE:
  - `apc_done == 1`: set `pd_on <= apc_power` and go to ACK.
  - Counter expires: pulse `req_err[w]`, set `fault`, go to FAULT.
- ACK: `req_ready[w] = 1` for exactly one cycle (registered). Next state is DWELL if a transition occurred and DWELL_CYCLES > 0, else IDLE.
- DWELL: count DWELL_CYCLES cycles, then go to IDLE. Requests wait.
- FAULT: `apc_power` is held and no grants are issued. When `fault_clr` is high: `pd_on <= apc_power`, `fault <= 0`, go to IDLE.
- The latched request is authoritative. Dropping `req_valid` or changing `req_on` after the latch does not abort the transaction; the ready pulse is still issued.
- A requester must hold `req_valid` and `req_on` stable until ready, and drop `req_valid` the cycle after ready. ACK→IDLE spacing guarantees the dropped request is never re-granted.
- `fault_clr` outside FAULT is ignored.

## Timing
- Same-state request: valid seen in IDLE at cycle t → ready at t+1 → IDLE at t+2. Maximum one grant per 2 cycles.
- Transition: `apc_power` changes at t+1 → GUARD at t+1..t+2 → WAIT_DONE from t+3. `apc_done` high at cycle d → `pd_on` updates and ready at d+1 → DWELL for DWELL_CYCLES cycles.
- Timeout: `req_err` pulses and `fault` rises the cycle after TIMEOUT_CYCLES WAIT_DONE cycles without `apc_done`.
- Reset mid-transaction returns every output to 0 asynchronously, including `apc_power=0`. This matches the wrapper's reset value of its previous-power register, so no spurious wrapper request results.
- Worst-case grant latency for one requester: (NREQ−1)·(4 + TIMEOUT_CYCLES + DWELL_CYCLES) cycles.

## Structure
- `pd_sched_pkg`: state enum `pd_sched_state_e`, guard length constant `PD_GUARD_CYCLES = 2`, counter width function `$clog2(max(DWELL_CYCLES, TIMEOUT_CYCLES)+1)`.
- One shared down-counter serves guard, timeout and dwell, since only one is active per state.
- Sub-module `pd_rr_arb`: combinational round-robin pick from `req_valid` and the pointer. Outputs are a one-hot grant and its index.

## Test plan
- Reset then requester 1 requests on: `apc_power` is 1 at t+1; model raises `apc_done` 5 cycles later → `pd_on=1`, one-cycle `req_ready=4'b0010`, `busy` low after 16 dwell cycles.
- Requester 2 requests on while `pd_on=1` → `req_ready[2]` at t+1, `apc_power` unchanged, no DWELL.
- Requesters 0 and 3 request off simultaneously, pointer at 2 → 3 granted first, 0 second. `apc_power` toggles once; 0 is acked at a same-state grant.
- `apc_done` never returns → `req_err` pulse to owner after 1024 WAIT_DONE cycles, `fault=1`, further requests ignored. `fault_clr` → IDLE with `pd_on` equal to `apc_power`.
- Assert `rst` low during WAIT_DONE → all outputs 0 immediately. After release, a new on request completes normally.
- `apc_done` held high throughout: GUARD masks it, so completion is accepted no earlier than t+3 after the `apc_power` change.
